// File: rtl/memory_access_controller_pkg.sv
// memory_access_controller_pkg
// Shared types and constants for the SRAM data-memory access controller:
// the sequencer state enum, default parameter values and the half-word select
// values that form the SRAM address LSB.
package memory_access_controller_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLow,
    StHigh,
    StDone
  } state_e;

  localparam int unsigned DefaultWaitStates    = 1;
  localparam int unsigned DefaultAddrBase      = 1024;
  localparam int unsigned DefaultSramAddrWidth = 18;

  // Width of the per-phase wait counter; holds the largest legal wait-state count (7).
  localparam int unsigned PhaseCntWidth = 3;

  // SRAM address LSB selecting the half of a 32-bit word.
  localparam logic HalfLow  = 1'b0;
  localparam logic HalfHigh = 1'b1;

endpackage

// File: rtl/phase_wait_counter.sv
// phase_wait_counter
// Counts the cycles spent in one SRAM phase, from 0 up to MaxCount.
// Ports:
//   clk_i   clock (posedge)
//   rst_i   synchronous active-high reset
//   clear_i return the count to 0 on the next edge (has priority over en_i)
//   en_i    advance the count; it saturates at MaxCount
//   last_o  high while the count equals MaxCount (final cycle of the phase)
module phase_wait_counter #(
  parameter int unsigned MaxCount = 1,
  parameter int unsigned Width    = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic last_o
);

  logic [Width-1:0] count_q, count_d;

  assign last_o = (count_q == Width'(MaxCount));

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && !last_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/memory_access_controller.sv
// memory_access_controller
// Replaces the single-cycle data memory: each 32-bit load/store from the MEM
// stage becomes a LOW then HIGH 16-bit access to an asynchronous SRAM, each
// phase lasting WAIT_STATES+1 cycles. ready is low while the pipeline must freeze.
// Ports:
//   clk, rst                              clock and synchronous active-high reset
//   memoryReadEnabled/memoryWriteEnabled  load/store request (sampled only in IDLE)
//   address, writeData                    byte address and store data
//   readData                              registered load result
//   ready                                 low = freeze the pipeline
//   sramAddr/sramDqOut/sramDqOe/sramWeN   registered SRAM drive signals
//   sramDqIn                              SRAM read data
// Optional feature: define MEMORY_ACCESS_CONTROLLER_READ_BUFFER_EN to add a
// one-entry buffer that answers a repeated load of the last-read word in IDLE.
module memory_access_controller
  import memory_access_controller_pkg::*;
#(
  parameter int unsigned WAIT_STATES     = DefaultWaitStates,
  parameter int unsigned ADDR_BASE       = DefaultAddrBase,
  parameter int unsigned SRAM_ADDR_WIDTH = DefaultSramAddrWidth
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       memoryReadEnabled,
  input  logic                       memoryWriteEnabled,
  input  logic [31:0]                address,
  input  logic [31:0]                writeData,
  output logic [31:0]                readData,
  output logic                       ready,
  output logic [SRAM_ADDR_WIDTH-1:0] sramAddr,
  output logic [15:0]                sramDqOut,
  output logic                       sramDqOe,
  input  logic [15:0]                sramDqIn,
  output logic                       sramWeN
);

  localparam int unsigned IdxWidth = SRAM_ADDR_WIDTH - 1;

  state_e state_q, state_d;
  logic                       is_write_q, is_write_d;
  logic [IdxWidth-1:0]        sram_idx_q, sram_idx_d;
  logic [31:0]                wdata_q, wdata_d;
  logic [31:0]                read_data_q, read_data_d;
  logic [SRAM_ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]                sram_dq_out_q, sram_dq_out_d;
  logic                       sram_dq_oe_q, sram_dq_oe_d;
  logic                       sram_we_n_q, sram_we_n_d;

  logic                req;
  logic                hit;
  logic                half;
  logic                cnt_last;
  logic [31:0]         word_offset;
  logic [IdxWidth-1:0] req_sram_idx;

  assign req          = memoryReadEnabled | memoryWriteEnabled;
  // Unsigned subtraction: addresses below the base wrap around modulo 2^32.
  assign word_offset  = address - 32'(ADDR_BASE);
  assign req_sram_idx = IdxWidth'(word_offset >> 2);

`ifdef MEMORY_ACCESS_CONTROLLER_READ_BUFFER_EN
  logic        buf_valid_q, buf_valid_d;
  logic [29:0] buf_idx_q, buf_idx_d;
  logic [29:0] req_idx;

  assign req_idx = 30'(word_offset >> 2);
  // A write request outranks the read, so it never counts as a hit.
  assign hit = (state_q == StIdle) & memoryReadEnabled & ~memoryWriteEnabled &
               buf_valid_q & (buf_idx_q == req_idx);
`else
  assign hit = 1'b0;
`endif

  assign ready = ~req | (state_q == StDone) | hit;

  phase_wait_counter #(
    .MaxCount (WAIT_STATES),
    .Width    (PhaseCntWidth)
  ) u_phase_wait_counter (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (state_d != state_q),
    .en_i    ((state_q == StLow) | (state_q == StHigh)),
    .last_o  (cnt_last)
  );

  always_comb begin
    state_d     = state_q;
    is_write_d  = is_write_q;
    sram_idx_d  = sram_idx_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;
`ifdef MEMORY_ACCESS_CONTROLLER_READ_BUFFER_EN
    buf_valid_d = buf_valid_q;
    buf_idx_d   = buf_idx_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req && !hit) begin
          state_d    = StLow;
          is_write_d = memoryWriteEnabled;
          sram_idx_d = req_sram_idx;
          wdata_d    = writeData;
`ifdef MEMORY_ACCESS_CONTROLLER_READ_BUFFER_EN
          // Invalidate up front; a read re-validates once its data is complete.
          buf_valid_d = 1'b0;
          buf_idx_d   = req_idx;
`endif
        end
      end
      StLow: begin
        if (cnt_last) begin
          state_d = StHigh;
          if (!is_write_q) read_data_d[15:0] = sramDqIn;
        end
      end
      StHigh: begin
        if (cnt_last) begin
          state_d = StDone;
          if (!is_write_q) begin
            read_data_d[31:16] = sramDqIn;
`ifdef MEMORY_ACCESS_CONTROLLER_READ_BUFFER_EN
            buf_valid_d = 1'b1;
`endif
          end
        end
      end
      StDone: state_d = StIdle;
    endcase
  end

  // SRAM outputs are registered, so they are decoded from the next state.
  always_comb begin
    sram_we_n_d   = 1'b1;
    sram_dq_oe_d  = 1'b0;
    sram_addr_d   = '0;
    sram_dq_out_d = '0;
    half          = (state_d == StHigh) ? HalfHigh : HalfLow;
    if ((state_d == StLow) || (state_d == StHigh)) begin
      sram_addr_d = {sram_idx_d, half};
      if (is_write_d) begin
        sram_we_n_d   = 1'b0;
        sram_dq_oe_d  = 1'b1;
        sram_dq_out_d = (half == HalfHigh) ? wdata_d[31:16] : wdata_d[15:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      is_write_q    <= 1'b0;
      sram_idx_q    <= '0;
      wdata_q       <= '0;
      read_data_q   <= '0;
      sram_addr_q   <= '0;
      sram_dq_out_q <= '0;
      sram_dq_oe_q  <= 1'b0;
      sram_we_n_q   <= 1'b1;
`ifdef MEMORY_ACCESS_CONTROLLER_READ_BUFFER_EN
      buf_valid_q   <= 1'b0;
      buf_idx_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      is_write_q    <= is_write_d;
      sram_idx_q    <= sram_idx_d;
      wdata_q       <= wdata_d;
      read_data_q   <= read_data_d;
      sram_addr_q   <= sram_addr_d;
      sram_dq_out_q <= sram_dq_out_d;
      sram_dq_oe_q  <= sram_dq_oe_d;
      sram_we_n_q   <= sram_we_n_d;
`ifdef MEMORY_ACCESS_CONTROLLER_READ_BUFFER_EN
      buf_valid_q   <= buf_valid_d;
      buf_idx_q     <= buf_idx_d;
`endif
    end
  end

  assign readData  = read_data_q;
  assign sramAddr  = sram_addr_q;
  assign sramDqOut = sram_dq_out_q;
  assign sramDqOe  = sram_dq_oe_q;
  assign sramWeN   = sram_we_n_q;

endmodule

// File: tb/tb_memory_access_controller.sv
// Bench for memory_access_controller (WAIT_STATES=1). A transaction-level model
// tracks cycles since each accepted request and is compared against the DUT on
// every negedge; directed sequences add literal expectations. Buffer-dependent
// expectations follow MEMORY_ACCESS_CONTROLLER_READ_BUFFER_EN.
module tb_memory_access_controller;

  localparam int W     = 1;
  localparam int DoneT = 2 * W + 3;

  logic        clk, rst, rd, wr;
  logic [31:0] address, writeData, readData;
  logic        ready, sramDqOe, sramWeN;
  logic [17:0] sramAddr;
  logic [15:0] sramDqOut, sramDqIn;

  memory_access_controller #(
    .WAIT_STATES     (W),
    .ADDR_BASE       (1024),
    .SRAM_ADDR_WIDTH (18)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .memoryReadEnabled  (rd),
    .memoryWriteEnabled (wr),
    .address            (address),
    .writeData          (writeData),
    .readData           (readData),
    .ready              (ready),
    .sramAddr           (sramAddr),
    .sramDqOut          (sramDqOut),
    .sramDqOe           (sramDqOe),
    .sramDqIn           (sramDqIn),
    .sramWeN            (sramWeN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pat(input int a);
    return 16'(a * 257) ^ 16'h5A5A;
  endfunction

  // Asynchronous SRAM environment (low 8 address bits decoded).
  logic [15:0] sram [0:255];
  assign sramDqIn = sram[sramAddr[7:0]];
  always @(posedge clk) if (!sramWeN) sram[sramAddr[7:0]] <= sramDqOut;

  // Behavioural model: word-level memory, cycles since request acceptance.
  logic [31:0] mwords [0:127];
  bit          m_busy, m_wr, m_bvalid;
  int          m_t;
  logic [31:0] m_idx, m_wdata, m_rdata, m_bidx;

  function automatic logic [31:0] widx(input logic [31:0] a);
    return (a - 32'd1024) >> 2;
  endfunction

  function automatic bit m_hit();
`ifdef MEMORY_ACCESS_CONTROLLER_READ_BUFFER_EN
    return !m_busy && rd && !wr && m_bvalid && (m_bidx == widx(address));
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_t = 0; m_rdata = '0; m_bvalid = 0;
    end else if (m_busy) begin
      m_t++;
      if (m_t == DoneT) begin
        if (!m_wr) begin
          m_rdata = mwords[m_idx[6:0]]; m_bvalid = 1; m_bidx = m_idx;
        end
      end else if (m_t > DoneT) begin
        m_busy = 0;
      end
    end else if ((rd || wr) && !m_hit()) begin
      m_busy = 1; m_t = 1; m_wr = wr; m_idx = widx(address); m_wdata = writeData;
      m_bvalid = 0;
      if (wr) mwords[m_idx[6:0]] = writeData;
    end
  end

  always @(negedge clk) begin
    logic        high;
    logic [17:0] ea;
    if (chk_en) begin
      check("ready", ready, (!(rd || wr) || m_hit() || (m_busy && m_t == DoneT)));
      if (m_busy && m_t < DoneT) begin
        high = (m_t > W + 1);
        ea   = {m_idx[16:0], high};
        check("sramAddr", sramAddr, ea);
        check("sramWeN", sramWeN, !m_wr);
        check("sramDqOe", sramDqOe, m_wr);
        if (m_wr) begin
          check("sramDqOut", sramDqOut, high ? m_wdata[31:16] : m_wdata[15:0]);
          check("readData_hold", readData, m_rdata);
        end
      end else begin
        check("idle_sramAddr", sramAddr, 0);
        check("idle_sramWeN", sramWeN, 1);
        check("idle_sramDqOe", sramDqOe, 0);
        check("idle_sramDqOut", sramDqOut, 0);
        check("readData", readData, m_rdata);
      end
    end
  end

  // Per-cycle trace of one access, index = cycles since the request appeared.
  int          n_low;
  logic [31:0] done_rdata;
  logic [17:0] tr_addr [0:31];
  logic [15:0] tr_dq   [0:31];
  logic        tr_we   [0:31];

  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d);
    bit got = 0;
    rd = r; wr = w; address = a; writeData = d;
    n_low = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      tr_addr[k] = sramAddr; tr_dq[k] = sramDqOut; tr_we[k] = sramWeN;
      if (ready) begin
        got = 1; done_rdata = readData;
        break;
      end
      n_low++;
    end
    check("access_completes", got, 1);
    @(posedge clk); #1;
    rd = 0; wr = 0;
  endtask

  initial begin
    bit all_we;
    rst = 1; rd = 0; wr = 0; address = '0; writeData = '0;
    for (int i = 0; i < 128; i++) begin
      sram[2*i]   = pat(2 * i);
      sram[2*i+1] = pat(2 * i + 1);
      mwords[i]   = {pat(2 * i + 1), pat(2 * i)};
    end
    repeat (2) @(posedge clk);
    #1 rst = 0; chk_en = 1;

    @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_weN", sramWeN, 1);
    check("rst_oe", sramDqOe, 0);
    check("rst_readData", readData, 0);
    @(posedge clk); #1;

    access(0, 1, 32'd1028, 32'hDEADBEEF);
    check("st_freeze", n_low, 5);
    check("st_addr1", tr_addr[1], 18'd2);
    check("st_dq1", tr_dq[1], 16'hBEEF);
    check("st_addr2", tr_addr[2], 18'd2);
    check("st_dq2", tr_dq[2], 16'hBEEF);
    check("st_addr3", tr_addr[3], 18'd3);
    check("st_dq3", tr_dq[3], 16'hDEAD);
    check("st_addr4", tr_addr[4], 18'd3);
    check("st_dq4", tr_dq[4], 16'hDEAD);
    check("st_we1", tr_we[1], 0);

    access(1, 0, 32'd1028, 32'h0);
    check("ld_freeze", n_low, 5);
    check("ld_data", done_rdata, 32'hDEADBEEF);
    all_we = 1;
    for (int k = 0; k <= 5; k++) all_we &= tr_we[k];
    check("ld_weN_high", all_we, 1);

    access(1, 1, 32'd1024, 32'h12345678);
    check("both_freeze", n_low, 5);
    check("both_readData", done_rdata, 32'hDEADBEEF);
    check("both_we1", tr_we[1], 0);
    check("both_dq1", tr_dq[1], 16'h5678);
    check("both_addr3", tr_addr[3], 18'd1);

    access(1, 0, 32'd1024, 32'h0);
    check("ld1024_data", done_rdata, 32'h12345678);

    access(1, 0, 32'd1028, 32'h0);
    check("ld1028_freeze", n_low, 5);
    access(1, 0, 32'd1028, 32'h0);
`ifdef MEMORY_ACCESS_CONTROLLER_READ_BUFFER_EN
    check("hit_freeze", n_low, 0);
    check("hit_weN", tr_we[0], 1);
`else
    check("rep_freeze", n_low, 5);
`endif
    check("rep_data", done_rdata, 32'hDEADBEEF);

    access(0, 1, 32'd1032, 32'hCAFEF00D);
    access(1, 0, 32'd1028, 32'h0);
    check("after_st_freeze", n_low, 5);
    check("after_st_data", done_rdata, 32'hDEADBEEF);

    access(1, 0, 32'd1040, 32'h0);
    check("unwritten_data", done_rdata, 32'h53535252);

    // Reset in the first HIGH cycle of a load.
    rd = 1; address = 32'd1024;
    repeat (3) @(posedge clk);
    #1 rst = 1; rd = 0;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("midrst_weN", sramWeN, 1);
    check("midrst_oe", sramDqOe, 0);
    check("midrst_readData", readData, 0);
    check("midrst_ready", ready, 1);
    @(posedge clk); #1;

    // Address below the base wraps to a large word index.
    access(0, 1, 32'd0, 32'hA5A50F0F);
    check("wrap_addr1", tr_addr[1], 18'h3FE00);
    check("wrap_addr3", tr_addr[3], 18'h3FE01);
    check("wrap_freeze", n_low, 5);

    repeat (2) @(posedge clk);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
